// File: rtl/stack_alu_sequencer.sv
// Micro-sequencer for a stack ALU datapath. It accepts RPN instructions
// (PUSH imm, ADD, MUL, POP) and expands each one into single-cycle primitive
// opcode pulses, every pulse followed by one idle gap cycle. It also tracks
// stack depth, rejects instructions the stack cannot satisfy, accumulates
// arithmetic overflow and hands popped values out over a result handshake.
module stack_alu_sequencer #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 50,
  parameter int DEPTH_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [1:0]         instr_op,
  input  logic [WIDTH-1:0]   instr_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               err,
  output logic               ovf_sticky,
  output logic [DEPTH_W-1:0] depth,
  output logic               busy,
  output logic [2:0]         stk_opcode,
  output logic [WIDTH-1:0]   stk_in,
  input  logic [WIDTH-1:0]   stk_out,
  input  logic               stk_overflow
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  localparam logic [2:0] PRIM_IDLE = 3'd0;
  localparam logic [2:0] PRIM_ADD  = 3'd4;
  localparam logic [2:0] PRIM_MUL  = 3'd5;
  localparam logic [2:0] PRIM_PUSH = 3'd6;
  localparam logic [2:0] PRIM_POP  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_GAP  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_imm;
  logic [WIDTH-1:0]     r_res;
  logic [1:0]           r_step;
  logic [DEPTH_W-1:0]   r_depth;
  logic                 r_err;
  logic                 r_ovf;
  logic [WIDTH-1:0]     r_res_data;
  logic                 w_accept;
  logic                 w_legal;
  logic                 w_arith;
  logic                 w_last_step;

  // An instruction is legal only if the stack holds enough operands (or room)
  function automatic logic is_legal(input logic [1:0] op,
                                    input logic [DEPTH_W-1:0] d);
    logic ok;
    case (op)
      OP_PUSH: ok = (d < DEPTH_W'(MAX_DEPTH));
      OP_POP:  ok = (d >= DEPTH_W'(1));
      default: ok = (d >= DEPTH_W'(2));
    endcase
    return ok;
  endfunction

  assign w_accept    = instr_valid && instr_ready;
  assign w_legal     = is_legal(instr_op, r_depth);
  assign w_arith     = (r_op == OP_ADD) || (r_op == OP_MUL);
  // ADD/MUL run four primitives (op, pop, pop, push); PUSH/POP run one
  assign w_last_step = w_arith ? (r_step == 2'd3) : 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: every primitive is an OP cycle followed by a GAP cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_legal) w_next = S_OP;
      S_OP:   w_next = S_GAP;
      S_GAP: begin
        if (w_last_step) w_next = (r_op == OP_POP) ? S_RESP : S_IDLE;
        else             w_next = S_OP;
      end
      S_RESP: if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode: primitive opcode and push data only during OP cycles
  always_comb begin
    stk_opcode  = PRIM_IDLE;
    stk_in      = '0;
    busy        = (r_state != S_IDLE);
    res_valid   = (r_state == S_RESP);
    instr_ready = (r_state == S_IDLE) && !rst;
    if (r_state == S_OP) begin
      case (r_op)
        OP_PUSH: begin
          stk_opcode = PRIM_PUSH;
          stk_in     = r_imm;
        end
        OP_POP: stk_opcode = PRIM_POP;
        default: begin
          if (r_step == 2'd0) begin
            stk_opcode = (r_op == OP_ADD) ? PRIM_ADD : PRIM_MUL;
          end else if (r_step == 2'd3) begin
            stk_opcode = PRIM_PUSH;
            stk_in     = r_res;
          end else begin
            stk_opcode = PRIM_POP;
          end
        end
      endcase
    end
  end

  // Instruction capture, step counter, depth, error pulse, overflow and result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= OP_PUSH;
      r_imm      <= '0;
      r_res      <= '0;
      r_step     <= 2'd0;
      r_depth    <= '0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_res_data <= '0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_accept) begin
        r_op   <= instr_op;
        r_imm  <= instr_data;
        r_step <= 2'd0;
      end
      if (r_state == S_GAP) begin
        // The datapath result is valid in the gap after the primitive
        if (w_arith && (r_step == 2'd0)) begin
          r_res <= stk_out;
          r_ovf <= r_ovf | stk_overflow;
        end
        if (r_op == OP_POP) r_res_data <= stk_out;
        if (w_last_step) begin
          r_step <= 2'd0;
          if (r_op == OP_PUSH) r_depth <= r_depth + DEPTH_W'(1);
          else                 r_depth <= r_depth - DEPTH_W'(1);
        end else begin
          r_step <= r_step + 2'd1;
        end
      end
    end
  end

  assign err        = r_err;
  assign ovf_sticky = r_ovf;
  assign depth      = r_depth;
  assign res_data   = r_res_data;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: a behavioural stack datapath answers the
// primitive opcodes, directed RPN programs drive the sequencer, and popped
// results are checked by a scoreboard monitor against hand-computed values.
module tb_stack_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_op;
  logic [7:0] instr_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       err;
  logic       ovf_sticky;
  logic [5:0] depth;
  logic       busy;
  logic [2:0] stk_opcode;
  logic [7:0] stk_in;
  logic [7:0] stk_out;
  logic       stk_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  stack_alu_sequencer #(.WIDTH(8), .MAX_DEPTH(50), .DEPTH_W(6)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_data(instr_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .ovf_sticky(ovf_sticky), .depth(depth), .busy(busy),
    .stk_opcode(stk_opcode), .stk_in(stk_in),
    .stk_out(stk_out), .stk_overflow(stk_overflow)
  );

  always #5 clk = ~clk;

  // Behavioural stack datapath: ADD/MUL report on the top two entries
  logic [7:0] stk_mem[64];
  int         sp = 0;
  always @(posedge clk) begin
    int full;
    if (rst) begin
      sp = 0;
      stk_out      <= 8'd0;
      stk_overflow <= 1'b0;
    end else begin
      case (stk_opcode)
        3'd6: begin stk_mem[sp] = stk_in; sp = sp + 1; end
        3'd7: begin
          if (sp > 0) begin sp = sp - 1; stk_out <= stk_mem[sp]; end
        end
        3'd4: begin
          full = int'(stk_mem[sp-1]) + int'(stk_mem[sp-2]);
          stk_out      <= full[7:0];
          stk_overflow <= (full > 255);
        end
        3'd5: begin
          full = int'(stk_mem[sp-1]) * int'(stk_mem[sp-2]);
          stk_out      <= full[7:0];
          stk_overflow <= (full > 255);
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare each handed-off result against the queue
  logic [2:0] prev_op = 3'd0;
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL res_unexpected: got %0d with no expected value", res_data);
      end else begin
        chk("res_data", 32'(res_data), 32'(exp_q.pop_front()));
      end
    end
    if (stk_opcode != 3'd0 && prev_op != 3'd0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL opcode_adjacent: got %0d after %0d required gap 0", stk_opcode, prev_op);
    end
    prev_op = stk_opcode;
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 100) begin @(negedge clk); n++; end
    if (!instr_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got instr_ready 0 required 1");
    end
    instr_valid = 1'b1; instr_op = op; instr_data = d;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(instr_ready && !busy) && n < 100) begin @(negedge clk); n++; end
    if (!(instr_ready && !busy)) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got busy %0d required 0", busy);
    end
  endtask

  task automatic push(input logic [7:0] d);
    issue(2'b00, d); wait_idle();
  endtask

  task automatic pop(input logic [7:0] e);
    exp_q.push_back(e); issue(2'b11, 8'd0); wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [2:0] tr[8];
    int n;
    tr = '{3'd4, 3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd6, 3'd0};
    rst = 1'b1; instr_valid = 1'b0; instr_op = 2'b00; instr_data = 8'd0; res_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_ready", 32'(instr_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ovf", 32'(ovf_sticky), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_opcode", 32'(stk_opcode), 32'd0);
    chk("rst_stk_in", 32'(stk_in), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);

    // PUSH 3, PUSH 4, ADD, POP -> 7
    push(8'd3); chk("depth_a1", 32'(depth), 32'd1);
    push(8'd4); chk("depth_a2", 32'(depth), 32'd2);
    issue(2'b01, 8'd0);
    for (int i = 0; i < 8; i++) begin
      chk("add_trace", 32'(stk_opcode), 32'(tr[i]));
      if (i == 7) chk("add_ready_T8", 32'(instr_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("add_ready_T9", 32'(instr_ready), 32'd1);
    chk("depth_a3", 32'(depth), 32'd1);
    chk("ovf_a", 32'(ovf_sticky), 32'd0);
    pop(8'd7); chk("depth_a4", 32'(depth), 32'd0);

    // Overflowing ADD and MUL
    push(8'd200); push(8'd100); issue(2'b01, 8'd0); wait_idle();
    chk("ovf_add", 32'(ovf_sticky), 32'd1);
    pop(8'd44);
    push(8'd16); push(8'd16); issue(2'b10, 8'd0); wait_idle();
    chk("ovf_mul", 32'(ovf_sticky), 32'd1);
    chk("depth_mul", 32'(depth), 32'd1);
    pop(8'd0);

    // Illegal: POP on empty, ADD with one entry
    issue(2'b11, 8'd0);
    chk("err_pop", 32'(err), 32'd1);
    chk("err_pop_opcode", 32'(stk_opcode), 32'd0);
    chk("err_pop_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("err_pop_pulse_end", 32'(err), 32'd0);
    chk("err_pop_opcode2", 32'(stk_opcode), 32'd0);
    chk("err_pop_depth", 32'(depth), 32'd0);
    push(8'd9);
    issue(2'b01, 8'd0);
    chk("err_add", 32'(err), 32'd1);
    chk("err_add_opcode", 32'(stk_opcode), 32'd0);
    wait_idle();
    chk("err_add_depth", 32'(depth), 32'd1);
    pop(8'd9);

    // Full stack
    do_reset();
    for (int i = 1; i <= 50; i++) push(8'(i));
    chk("full_depth", 32'(depth), 32'd50);
    issue(2'b00, 8'd99);
    chk("err_full", 32'(err), 32'd1);
    chk("err_full_opcode", 32'(stk_opcode), 32'd0);
    wait_idle();
    chk("full_depth2", 32'(depth), 32'd50);
    pop(8'd50);
    chk("full_depth3", 32'(depth), 32'd49);

    // Result back-pressure
    push(8'h5A);
    res_ready = 1'b0;
    exp_q.push_back(8'h5A);
    issue(2'b11, 8'd0);
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("stall_res_valid_seen", 32'(res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_res_valid", 32'(res_valid), 32'd1);
      chk("stall_res_data", 32'(res_data), 32'h5A);
      chk("stall_instr_ready", 32'(instr_ready), 32'd0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_ready", 32'(instr_ready), 32'd1);
    chk("post_hs_valid", 32'(res_valid), 32'd0);

    // Reset in the middle of a MUL
    push(8'd20); push(8'd20);
    issue(2'b10, 8'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_mul_ovf", 32'(ovf_sticky), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_rst_ready", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_opcode", 32'(stk_opcode), 32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_sticky), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_opcode_quiet", 32'(stk_opcode), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
